// File: rtl/sweep_activity_ctrl.sv
// rtl/sweep_activity_ctrl.sv - exhaustive input sweep of a combinational sub-circuit with activity counters
// Build option: SWEEP_GRAY_ORDER_EN selects Gray-ordered vectors instead of binary order.
module sweep_activity_ctrl #(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   ones_cnt,
    output logic [N_IN:0]   out_tgl_cnt,
    output logic [N_IN+1:0] in_tgl_cnt
);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] IDX_ONE  = 1;
    localparam logic [N_IN:0]   CNT_ONE  = 1;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [N_IN-1:0]   prev_vec_q, prev_vec_d;
    logic              prev_smp_q, prev_smp_d;
    logic [N_IN:0]     ones_q, ones_d;
    logic [N_IN:0]     out_tgl_q, out_tgl_d;
    logic [N_IN+1:0]   in_tgl_q, in_tgl_d;

    function automatic logic [N_IN-1:0] vec_of(input logic [N_IN-1:0] i);
`ifdef SWEEP_GRAY_ORDER_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    function automatic logic [N_IN+1:0] popcnt(input logic [N_IN-1:0] v);
        logic [N_IN+1:0] c;
        c = '0;
        for (int b = 0; b < N_IN; b++) begin
            c = c + {{(N_IN+1){1'b0}}, v[b]};
        end
        return c;
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        vec_d      = vec_q;
        prev_vec_d = prev_vec_q;
        prev_smp_d = prev_smp_q;
        ones_d     = ones_q;
        out_tgl_d  = out_tgl_q;
        in_tgl_d   = in_tgl_q;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = APPLY;
                    idx_d     = '0;
                    vec_d     = vec_of('0);
                    ones_d    = '0;
                    out_tgl_d = '0;
                    in_tgl_d  = '0;
                end
            end
            APPLY: begin
                // The vector register is loaded on entry to APPLY, so it is stable through SAMPLE.
                busy       = 1'b1;
                state_d    = SAMPLE;
                prev_vec_d = vec_q;
                if (idx_q != '0) begin
                    in_tgl_d = in_tgl_q + popcnt(vec_q ^ prev_vec_q);
                end
            end
            SAMPLE: begin
                busy       = 1'b1;
                prev_smp_d = dut_out;
                ones_d     = ones_q + {{N_IN{1'b0}}, dut_out};
                if ((idx_q != '0) && (dut_out != prev_smp_q)) begin
                    out_tgl_d = out_tgl_q + CNT_ONE;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = APPLY;
                    idx_d   = idx_q + IDX_ONE;
                    vec_d   = vec_of(idx_q + IDX_ONE);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            vec_q      <= '0;
            prev_vec_q <= '0;
            prev_smp_q <= 1'b0;
            ones_q     <= '0;
            out_tgl_q  <= '0;
            in_tgl_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            vec_q      <= vec_d;
            prev_vec_q <= prev_vec_d;
            prev_smp_q <= prev_smp_d;
            ones_q     <= ones_d;
            out_tgl_q  <= out_tgl_d;
            in_tgl_q   <= in_tgl_d;
        end
    end

    assign dut_in      = vec_q;
    assign ones_cnt    = ones_q;
    assign out_tgl_cnt = out_tgl_q;
    assign in_tgl_cnt  = in_tgl_q;

endmodule

// File: tb/tb_sweep_activity_ctrl.sv
// tb/tb_sweep_activity_ctrl.sv - directed self-checking bench for sweep_activity_ctrl (N_IN=4)
module tb_sweep_activity_ctrl;

    localparam int N_IN = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic [N_IN:0]   ones_cnt;
    logic [N_IN:0]   out_tgl_cnt;
    logic [N_IN+1:0] in_tgl_cnt;

    int mode;
    int vectors = 0;
    int miscompares = 0;
    int cyc;
    int dones;

`ifdef SWEEP_GRAY_ORDER_EN
    localparam int IN_TGL   = 15;
    localparam int B0_TGL   = 8;
    localparam int AND_TGL  = 2;
    localparam int LAST_VEC = 8;
`else
    localparam int IN_TGL   = 26;
    localparam int B0_TGL   = 15;
    localparam int AND_TGL  = 1;
    localparam int LAST_VEC = 15;
`endif

    always #5 clk = ~clk;

    assign dut_out = (mode == 0) ? 1'b0 : (mode == 1) ? dut_in[0] : (&dut_in);

    sweep_activity_ctrl #(.N_IN(N_IN)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dut_in     (dut_in),
        .dut_out    (dut_out),
        .busy       (busy),
        .done       (done),
        .ones_cnt   (ones_cnt),
        .out_tgl_cnt(out_tgl_cnt),
        .in_tgl_cnt (in_tgl_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; cyc counts negedges since the accepting edge.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        dones = 0;
    endtask

    task automatic wait_done(input int mid_start_cyc);
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = (cyc == mid_start_cyc);
            if (done) dones++;
        end
        start = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int o, input int t, input int i);
        chk({tag, "_ones"},   32'(ones_cnt),    32'(o));
        chk({tag, "_outtgl"}, 32'(out_tgl_cnt), 32'(t));
        chk({tag, "_intgl"},  32'(in_tgl_cnt),  32'(i));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dut_in", 32'(dut_in), 0);
        check_counts("rst", 0, 0, 0);
        rst_n = 1'b1;

        // Tied-low output.
        pulse_start();
        chk("t0_busy_apply", 32'(busy), 1);
        wait_done(0);
        chk("t0_latency", 32'(cyc), 33);
        chk("t0_done", 32'(done), 1);
        chk("t0_busy_in_done", 32'(busy), 0);
        check_counts("t0", 0, 0, IN_TGL);
        @(negedge clk);
        chk("t0_done_pulse", 32'(done), 0);

        // Output follows bit 0.
        mode = 1;
        pulse_start();
        wait_done(0);
        chk("b0_latency", 32'(cyc), 33);
        check_counts("b0", 8, B0_TGL, IN_TGL);

        // AND of all inputs; hold start through DONE so it is taken on the first IDLE cycle.
        mode = 2;
        pulse_start();
        wait_done(0);
        chk("and_latency", 32'(cyc), 33);
        check_counts("and", 1, AND_TGL, IN_TGL);
        chk("and_dut_in_done", 32'(dut_in), LAST_VEC);
        start = 1'b1;
        @(negedge clk);
        chk("hold_idle_busy", 32'(busy), 0);
        chk("hold_idle_dut_in", 32'(dut_in), LAST_VEC);
        chk("hold_idle_ones", 32'(ones_cnt), 1);
        @(negedge clk);
        start = 1'b0;
        chk("hold_accept_busy", 32'(busy), 1);
        chk("hold_clr_ones", 32'(ones_cnt), 0);
        cyc = 1;
        wait_done(0);
        chk("hold_latency", 32'(cyc), 33);

        // Start pulsed mid-sweep is ignored.
        mode = 1;
        pulse_start();
        wait_done(10);
        chk("mid_latency", 32'(cyc), 33);
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("mid_dones", 32'(dones), 1);
        check_counts("mid", 8, B0_TGL, IN_TGL);

        // Reset mid-sweep discards partial results.
        pulse_start();
        repeat (11) begin
            @(negedge clk);
            cyc++;
        end
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(done), 0);
        chk("mrst_dut_in", 32'(dut_in), 0);
        check_counts("mrst", 0, 0, 0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("mrst_no_done", 32'(dones), 0);
        pulse_start();
        wait_done(0);
        chk("post_rst_latency", 32'(cyc), 33);
        check_counts("post_rst", 8, B0_TGL, IN_TGL);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sweep_activity_ctrl.md
SWEEP_ACTIVITY_CTRL -- requirements
Module: sweep_activity_ctrl

Interface
REQ-001 Parameter N_IN, default 4, input count of the combinational sub-circuit under control (legal 2..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  request a full sweep; sampled only in IDLE.
REQ-005 dut_in  output  N_IN  stimulus vector driven to the sub-circuit inputs.
REQ-006 dut_out  input  1  sub-circuit output, combinational from dut_in.
REQ-007 busy  output  1  high while a sweep is running.
REQ-008 done  output  1  one-cycle pulse when results are valid.
REQ-009 ones_cnt  output  N_IN+1  number of vectors for which dut_out sampled 1.
REQ-010 out_tgl_cnt  output  N_IN+1  dut_out changes between consecutive samples.
REQ-011 in_tgl_cnt  output  N_IN+2  total dut_in bit flips across the sweep.

Function
REQ-012 FSM states IDLE, APPLY, SAMPLE, DONE; exactly one active per cycle.
REQ-013 IDLE with start=1 -> APPLY; vector index cleared to 0; all three counters cleared on that edge.
REQ-014 APPLY: dut_in driven with the vector for the current index; the next state is always SAMPLE.
REQ-015 SAMPLE: dut_out registered; ones_cnt += dut_out; out_tgl_cnt += (dut_out != previous sample), except at index 0, where no comparison is made.
REQ-016 SAMPLE with index < 2^N_IN-1 -> index+1, APPLY; with index = 2^N_IN-1 -> DONE; the index does not wrap.
REQ-017 in_tgl_cnt += popcount(new vector XOR previous vector) at each APPLY after index 0; index 0 adds nothing.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE; the counters hold until the next accepted start.
REQ-019 busy=1 in APPLY and SAMPLE only; done=1 in DONE only.
REQ-020 start is ignored in APPLY, SAMPLE and DONE; no queuing; start held high in DONE is accepted on the first IDLE cycle.
REQ-021 Latency: with start accepted at edge k, done is high during the cycle after edge k+2*2^N_IN (33 cycles for N_IN=4).
REQ-022 dut_in holds its last value in IDLE and DONE, so the sub-circuit sees no spurious activity.
REQ-023 Counter widths are sized so that no counter can overflow for any N_IN in range.

Reset
REQ-024 rst_n=0 at any edge forces IDLE, dut_in=0, busy=0, done=0 and all counters to 0, including mid-sweep; no partial results are retained.
REQ-025 The previous-sample and previous-vector registers reset to 0.

Configuration
REQ-026 Macro SWEEP_GRAY_ORDER_EN defined: vector = index XOR (index >> 1), i.e. Gray order, giving one input flip per step.
REQ-027 Macro SWEEP_GRAY_ORDER_EN undefined: vector = index, i.e. binary order.
REQ-028 Ports, FSM and latency are identical in both builds.

Verification
REQ-029 N_IN=4, binary build, dut_out tied 0, start pulse -> done 33 cycles later; ones_cnt=0, out_tgl_cnt=0, in_tgl_cnt=26.
REQ-030 Binary build, dut_out=dut_in[0] -> ones_cnt=8, out_tgl_cnt=15, in_tgl_cnt=26.
REQ-031 Gray build, dut_out=dut_in[0] -> ones_cnt=8, out_tgl_cnt=8, in_tgl_cnt=15.
REQ-032 Binary build, dut_out=AND of all inputs -> ones_cnt=1, out_tgl_cnt=1; dut_in=15 after done.
REQ-033 start pulsed at cycle 10 of a sweep -> no effect; exactly one done; counts equal REQ-030 values.
REQ-034 rst_n=0 for one edge at cycle 12 of a sweep -> busy=0, all counters 0, dut_in=0, no done; a new start then completes normally.
